// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and line levels used by the TX and RX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic LineIdle  = 1'b1;
    localparam logic LineStart = 1'b0;

    localparam int unsigned DataBitsDefault = 8;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, start/data/parity/stop framing on o_tx,
// paced by an external one-cycle baud tick. All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DataBitsDefault,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_baud_tick,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int unsigned   CntW      = $clog2(DATA_BITS) + 1;
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS - 1);
    localparam logic          ParityOdd = (PARITY_ODD != 0);
    localparam logic          ParityEn  = (PARITY_EN != 0);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 parity_q, parity_d;
    // Next frame already latched during the final stop bit.
    logic                 pending_q, pending_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic handshake;

    assign handshake = i_valid & ready_q;

    // Next-state logic: frame sequencing and data latching.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        parity_d  = parity_q;
        pending_d = pending_q;

        unique case (state_q)
            StIdle: begin
                // Tick ignored here so the start bit always gets a full period.
                if (handshake) begin
                    shift_d  = i_data;
                    parity_d = (^i_data) ^ ParityOdd;
                    state_d  = StSync;
                end
            end
            StSync: begin
                if (i_baud_tick) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (i_baud_tick) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (i_baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == DataLast) begin
                        cnt_d   = '0;
                        state_d = ParityEn ? StParity : StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (i_baud_tick) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end
            end
            StStop: begin
                // Handshake only possible in the final stop bit (ready gated).
                if (handshake) begin
                    shift_d   = i_data;
                    parity_d  = (^i_data) ^ ParityOdd;
                    pending_d = 1'b1;
                end
                if (i_baud_tick) begin
                    if (cnt_q == StopLast) begin
                        cnt_d     = '0;
                        pending_d = 1'b0;
                        if (handshake) begin
                            state_d = StSync;
                        end else if (pending_q) begin
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from next state so the registered outputs track the state register.
    always_comb begin
        tx_d = LineIdle;
        unique case (state_d)
            StStart:  tx_d = LineStart;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = LineIdle;
        endcase
        ready_d = (state_d == StIdle) ||
                  ((state_d == StStop) && (cnt_d == StopLast) && !pending_d);
        busy_d  = (state_d != StIdle);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            parity_q  <= 1'b0;
            pending_q <= 1'b0;
            tx_q      <= LineIdle;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            parity_q  <= parity_d;
            pending_q <= pending_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) on a shared
// 16-clk baud tick; frames are sampled every clk and compared per bit period.
module tb_uart_tx;

    logic            clk = 1'b0;
    logic            reset;
    logic            tick;
    logic [3:0][7:0] data_v;
    logic [3:0]      valid_v;
    logic [3:0]      ready_v;
    logic [3:0]      tx_v;
    logic [3:0]      busy_v;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .reset(reset), .i_baud_tick(tick), .i_data(data_v[0]),
        .i_valid(valid_v[0]), .o_ready(ready_v[0]), .o_tx(tx_v[0]), .o_busy(busy_v[0])
    );
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
        .clk(clk), .reset(reset), .i_baud_tick(tick), .i_data(data_v[1]),
        .i_valid(valid_v[1]), .o_ready(ready_v[1]), .o_tx(tx_v[1]), .o_busy(busy_v[1])
    );
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
        .clk(clk), .reset(reset), .i_baud_tick(tick), .i_data(data_v[2]),
        .i_valid(valid_v[2]), .o_ready(ready_v[2]), .o_tx(tx_v[2]), .o_busy(busy_v[2])
    );
    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .reset(reset), .i_baud_tick(tick), .i_data(data_v[3]),
        .i_valid(valid_v[3]), .o_ready(ready_v[3]), .o_tx(tx_v[3]), .o_busy(busy_v[3])
    );

    // Baud tick: one clk high every 16 clk.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (15) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the start bit appears on line idx; leaves us on its first negedge.
    task automatic wait_start(input int idx, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 48 && !found; i++) begin
            if (tx_v[idx] == 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check({name, "_start_seen"}, 32'(found), 32'd1);
    endtask

    // Send one byte on instance idx and check each bit period holds the expected level
    // for exactly 16 clk. poke: drive 0xFF/valid during DATA. rst_mid: reset in data bit 3.
    task automatic send_frame(input int idx, input logic [7:0] b, input int nbits,
                              input logic [15:0] exp, input bit poke, input bit rst_mid,
                              input string name);
        int  good[16];
        int  busy_lo = 0;
        int  rdy_hi  = 0;
        bit  aborted = 1'b0;
        for (int j = 0; j < 16; j++) good[j] = 0;

        @(negedge clk);
        check({name, "_ready_idle"}, 32'(ready_v[idx]), 32'd1);
        data_v[idx]  = b;
        valid_v[idx] = 1'b1;
        @(negedge clk);
        valid_v[idx] = 1'b0;
        wait_start(idx, name);

        for (int k = 0; k < nbits * 16; k++) begin
            if (k != 0) @(negedge clk);
            if (poke && k == 40) begin
                data_v[idx]  = 8'hFF;
                valid_v[idx] = 1'b1;
            end
            if (poke && k == 120) valid_v[idx] = 1'b0;
            if (rst_mid && k == 70) begin
                reset = 1'b0;
                #1;
                check({name, "_async_tx"}, 32'(tx_v[idx]), 32'd1);
                check({name, "_async_busy"}, 32'(busy_v[idx]), 32'd0);
                check({name, "_async_ready"}, 32'(ready_v[idx]), 32'd1);
                repeat (3) @(negedge clk);
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (tx_v[idx] == exp[k / 16]) good[k / 16]++;
            if (!busy_v[idx]) busy_lo++;
            if (poke && k >= 40 && k < 120 && ready_v[idx]) rdy_hi++;
        end

        if (!aborted) begin
            for (int j = 0; j < nbits; j++) begin
                check($sformatf("%s_bit%0d", name, j), 32'(good[j]), 32'd16);
            end
            check({name, "_busy_in_frame"}, 32'(busy_lo), 32'd0);
            if (poke) check({name, "_ready_while_busy"}, 32'(rdy_hi), 32'd0);
            @(negedge clk);
            check({name, "_busy_end"}, 32'(busy_v[idx]), 32'd0);
            check({name, "_ready_end"}, 32'(ready_v[idx]), 32'd1);
            check({name, "_tx_end"}, 32'(tx_v[idx]), 32'd1);
        end
    endtask

    initial begin
        int          glitches;
        int          good2[22];
        int          busy_lo;
        int          acc;
        bit          drop;
        logic [21:0] exp22;

        valid_v = '0;
        data_v  = '0;
        reset   = 1'b1;
        #2 reset = 1'b0;

        // Held in reset with ticks and valid data present: everything stays idle.
        valid_v = 4'hF;
        for (int i = 0; i < 4; i++) data_v[i] = 8'hA5;
        glitches = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_v !== 4'hF || ready_v !== 4'hF || busy_v !== 4'h0) glitches++;
        end
        check("rst_hold_glitches", 32'(glitches), 32'd0);
        check("rst_tx", 32'(tx_v), 32'hF);
        check("rst_ready", 32'(ready_v), 32'hF);
        check("rst_busy", 32'(busy_v), 32'h0);
        valid_v = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 32'(busy_v), 32'h0);

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        send_frame(0, 8'h55, 10, {6'd0, 1'b1, 8'h55, 1'b0}, 1'b0, 1'b0, "n1_55");
        // 0xA7 has five ones: even parity 1, odd parity 0
        send_frame(1, 8'hA7, 11, {5'd0, 1'b1, 1'b1, 8'hA7, 1'b0}, 1'b0, 1'b0, "e1_a7");
        send_frame(2, 8'hA7, 11, {5'd0, 1'b1, 1'b0, 8'hA7, 1'b0}, 1'b0, 1'b0, "o1_a7");
        // New data offered during DATA must not disturb the frame
        send_frame(0, 8'h5A, 10, {6'd0, 1'b1, 8'h5A, 1'b0}, 1'b1, 1'b0, "busy_ign");

        // Back-to-back 0x01 then 0x80 with two stop bits, valid held high.
        exp22 = {1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
        for (int j = 0; j < 22; j++) good2[j] = 0;
        busy_lo = 0;
        acc     = 0;
        drop    = 1'b0;
        @(negedge clk);
        check("b2b_ready_idle", 32'(ready_v[3]), 32'd1);
        data_v[3]  = 8'h01;
        valid_v[3] = 1'b1;
        @(negedge clk);
        data_v[3] = 8'h80;
        wait_start(3, "b2b");
        for (int k = 0; k < 352; k++) begin
            if (k != 0) @(negedge clk);
            if (drop) begin
                valid_v[3] = 1'b0;
                drop       = 1'b0;
            end
            if (tx_v[3] == exp22[k / 16]) good2[k / 16]++;
            if (!busy_v[3]) busy_lo++;
            if (valid_v[3] && ready_v[3]) begin
                drop = 1'b1;
                acc++;
            end
        end
        for (int j = 0; j < 22; j++) begin
            check($sformatf("b2b_bit%0d", j), 32'(good2[j]), 32'd16);
        end
        check("b2b_accepts", 32'(acc), 32'd1);
        check("b2b_busy_gap", 32'(busy_lo), 32'd0);
        @(negedge clk);
        check("b2b_busy_end", 32'(busy_v[3]), 32'd0);
        check("b2b_ready_end", 32'(ready_v[3]), 32'd1);

        // Reset mid-frame, then a clean frame afterwards
        send_frame(0, 8'h3C, 10, {6'd0, 1'b1, 8'h3C, 1'b0}, 1'b0, 1'b1, "rst_mid");
        repeat (2) @(negedge clk);
        check("rst_mid_tx_idle", 32'(tx_v[0]), 32'd1);
        send_frame(0, 8'h3C, 10, {6'd0, 1'b1, 8'h3C, 1'b0}, 1'b0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
